uart_rx: RTL
============

Name: uart_rx

Overview:
UART receiver, the consumer of the serial line produced by the transmit datapath. Frame format is 8N1: one low start bit, 8 data bits LSB first, one high stop bit, idle high. The block synchronises the asynchronous rx pin, detects start bits, and samples each bit at mid-bit using an internal baud counter. It delivers each received byte through a one-entry holding register with a valid/ready handshake, and flags framing and overrun errors.

Parameters:
CLKS_PER_BIT, 5208, system clocks per bit (50 MHz / 9600 baud); must be >= 4
HALF_BIT, CLKS_PER_BIT/2 (integer division), clocks from start-edge detect to the start-bit sample point

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
rx  input  1  serial line, asynchronous to clk, idle high
rx_ready  input  1  consumer accepts rx_data this cycle when rx_valid=1
rx_data  output  8  received byte, stable while rx_valid=1
rx_valid  output  1  holding register contains an unconsumed byte
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: byte completed while holding register full and not being read
busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset (async, active-high): rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, baud counter=0, bit index=0, both synchroniser flops=1 (line reads idle).
- rx passes through a 2-flop synchroniser; rx_s is the second flop. All decisions use rx_s. Pin-to-rx_s latency is 2 clocks.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: first cycle with rx_s=0 defines t0. Go to START and clear the baud counter.
- START: at t0+HALF_BIT, sample rx_s.
  - If rx_s=0: valid start bit; go to DATA with bit index 0.
  - If rx_s=1: glitch; return to IDLE with no flags.
- DATA: data bit i (i=0..7) is sampled at t0+HALF_BIT+(i+1)*CLKS_PER_BIT and shifted into an internal shift register, LSB first. After bit 7, go to STOP.
- STOP: stop bit is sampled at t0+HALF_BIT+9*CLKS_PER_BIT.
  - If rx_s=1: byte complete; go to IDLE.
  - If rx_s=0: frame_err pulses for the next cycle; the byte is discarded; go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1, then go to IDLE. This prevents a stuck-low line (break) from producing repeated frames.
- Byte-complete hand-off to the holding register, on the cycle after the stop sample:
  - rx_valid=0: load rx_data; rx_valid=1.
  - rx_valid=1 and rx_ready=1 in the same cycle: load the new byte; rx_valid stays 1; no overrun.
  - rx_valid=1 and rx_ready=0: keep the old rx_data; drop the new byte; overrun pulses for 1 cycle.
- Handshake:
  - rx_valid clears on the cycle after rx_valid & rx_ready, unless a new byte loads in that same cycle.
  - rx_ready while rx_valid=0 has no effect.
  - rx_data never changes while rx_valid=1 except on an accepted load.
- Back-to-back frames: IDLE is re-entered at the mid-stop sample point. A start edge arriving after that is detected normally, so full line-rate reception is supported.
- Baud counter width: clog2(CLKS_PER_BIT). It resets to 0 at each sample point and never wraps past CLKS_PER_BIT-1.
- Reset mid-frame aborts immediately. After release, reception resumes only on a new falling edge seen in IDLE.

Test Plan (CLKS_PER_BIT=16 for simulation):
- Single byte 8'hA5 sent at 16 clk/bit, rx_ready=0 -> rx_valid rises exactly 2+8+9*16+1 clocks after the pin falls; rx_data=8'hA5; frame_err=0.
- Handshake: after 8'hA5, pulse rx_ready for 1 cycle -> rx_valid=0 the next cycle. Then send 8'h3C back-to-back with 8'h00 -> two valid bytes delivered in order, no errors.
- Glitch: rx low for 5 clocks, then high -> FSM returns to IDLE, busy drops, no rx_valid, no flags.
- Framing error: send 8'hFF with stop bit forced low and the line held low for 40 clocks -> frame_err 1-cycle pulse, rx_valid stays 0, busy stays high until the line returns high, no second frame.
- Overrun: receive 8'h11 (not read), then 8'h22 -> overrun pulse; rx_data stays 8'h11. Repeat with rx_ready asserted on the 8'h22 load cycle -> rx_data=8'h22, no overrun.
- Reset: assert reset during data bit 4 of a frame -> all outputs return to reset values immediately; the rest of the frame produces no rx_valid; the next full frame 8'h5A is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-flop synchroniser, mid-bit sampling,
// one-entry valid/ready holding register, framing and overrun pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t        state, state_nx;
    logic          rx_m, rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic          tick, done, bad;

    always_ff @(posedge clk or posedge reset)
        if (reset) {rx_m, rx_s} <= 2'b11;
        else       {rx_m, rx_s} <= {rx, rx_m};

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nx;

    always_comb begin
        tick     = (state == START) ? (cnt == CW'(HALF_BIT - 1)) : (cnt == CW'(CLKS_PER_BIT - 1));
        state_nx = state;
        done     = 1'b0;
        bad      = 1'b0;
        case (state)
            IDLE:      if (!rx_s) state_nx = START;
            START:     if (tick) state_nx = rx_s ? IDLE : DATA;
            DATA:      if (tick && idx == 3'd7) state_nx = STOP;
            STOP: if (tick) begin
                state_nx = rx_s ? IDLE : WAIT_IDLE;
                done     = rx_s;
                bad      = !rx_s;
            end
            WAIT_IDLE: if (rx_s) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Counter restarts at every sample point so each phase measures from the last sample
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else       cnt <= (state == IDLE || state == WAIT_IDLE || tick) ? '0 : cnt + 1'b1;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            idx   <= '0;
            shift <= '0;
        end else if (state == START) begin
            idx <= '0;
        end else if (state == DATA && tick) begin
            shift <= {rx_s, shift[7:1]};
            idx   <= idx + 1'b1;
        end

    // A completed byte only overwrites the holding register if it is empty or being read now
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= bad;
            overrun   <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end

    assign busy = (state != IDLE);
endmodule
